// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter: fetch and data masters share one line-memory
// slave port with round-robin tie breaking and a per-grant ack watchdog.
module wb_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 128,
  parameter int SEL_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_cyc,
  input  logic              if_stb,
  input  logic              if_we,
  input  logic [ADDR_W-1:0] if_adr,
  input  logic [DATA_W-1:0] if_dat_m,
  input  logic [SEL_W-1:0]  if_sel,
  output logic [DATA_W-1:0] if_dat_s,
  output logic              if_ack,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_m,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_dat_m,
  output logic [SEL_W-1:0]  m_sel,
  input  logic [DATA_W-1:0] m_dat_s,
  input  logic              m_ack,
  output logic              timeout_err
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t          state;
  logic            last;
  logic [WD_W-1:0] wd;

  logic if_req;
  logic d_req;
  logic wd_fire;

  assign if_req  = if_cyc & if_stb;
  assign d_req   = d_cyc & d_stb;
  // fires on the cycle whose no-ack would make wd reach TIMEOUT
  assign wd_fire = (TIMEOUT != 0) && (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (if_req && d_req)
            state <= last ? GNT_I : GNT_D;
          else if (if_req)
            state <= GNT_I;
          else if (d_req)
            state <= GNT_D;
        end
        GNT_I: begin
          if (m_ack) begin
            last <= 1'b0;
            wd   <= '0;
            if (d_req)
              state <= GNT_D;
            else if (!if_req)
              state <= IDLE;
          end else if (!if_cyc) begin
            state <= IDLE;
          end else if (wd_fire) begin
            state       <= IDLE;
            last        <= 1'b0;
            timeout_err <= 1'b1;
          end else if (wd != '1) begin
            wd <= wd + WD_W'(1);
          end
        end
        GNT_D: begin
          if (m_ack) begin
            last <= 1'b1;
            wd   <= '0;
            if (if_req)
              state <= GNT_I;
            else if (!d_req)
              state <= IDLE;
          end else if (!d_cyc) begin
            state <= IDLE;
          end else if (wd_fire) begin
            state       <= IDLE;
            last        <= 1'b1;
            timeout_err <= 1'b1;
          end else if (wd != '1) begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat_m = '0;
    m_sel   = '0;
    unique case (state)
      GNT_I: begin
        m_cyc   = if_req;
        m_stb   = if_req;
        m_we    = if_we;
        m_adr   = if_adr;
        m_dat_m = if_dat_m;
        m_sel   = if_sel;
      end
      GNT_D: begin
        m_cyc   = d_req;
        m_stb   = d_req;
        m_we    = d_we;
        m_adr   = d_adr;
        m_dat_m = d_dat_m;
        m_sel   = d_sel;
      end
      default: ;
    endcase
  end

  assign if_ack   = m_ack & (state == GNT_I);
  assign d_ack    = m_ack & (state == GNT_D);
  assign if_dat_s = m_dat_s;
  assign d_dat_s  = m_dat_s;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: reference model plus per-cycle compare and
// directed fetch/data scenarios against a programmable-wait slave.
module tb_wb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_cyc = 1'b0, if_stb = 1'b0, if_we = 1'b0;
  logic [AW-1:0] if_adr = '0;
  logic [DW-1:0] if_dat_m = '0;
  logic [SW-1:0] if_sel = '0;
  logic [DW-1:0] if_dat_s;
  logic          if_ack;
  logic          d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_adr = '0;
  logic [DW-1:0] d_dat_m = '0;
  logic [SW-1:0] d_sel = '0;
  logic [DW-1:0] d_dat_s;
  logic          d_ack;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_m;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_dat_s = '0;
  logic          m_ack = 1'b0;
  logic          timeout_err;

  int cmp_n = 0;
  int bad_n = 0;

  int ack_wait = 2;
  int s_cnt = 0;
  int i_rem = 0;
  int d_rem = 0;
  bit i_seen = 0;
  bit d_seen = 0;

  // model: owner 0 = nobody, 1 = fetch, 2 = data
  int owner = 0;
  bit last_d = 0;
  int waited = 0;
  bit err_m = 0;
  bit ir, dr, mine_req, other_req, mine_cyc;

  logic [162:0] exp_bus;

  always #5 clk = ~clk;

  wb_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_cyc(if_cyc), .if_stb(if_stb), .if_we(if_we),
    .if_adr(if_adr), .if_dat_m(if_dat_m), .if_sel(if_sel),
    .if_dat_s(if_dat_s), .if_ack(if_ack),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we),
    .d_adr(d_adr), .d_dat_m(d_dat_m), .d_sel(d_sel),
    .d_dat_s(d_dat_s), .d_ack(d_ack),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat_m(m_dat_m), .m_sel(m_sel),
    .m_dat_s(m_dat_s), .m_ack(m_ack),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] req);
    cmp_n++;
    if (act !== req) begin
      bad_n++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference model of who owns the bus after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0;
      last_d = 0;
      waited = 0;
      err_m = 0;
    end else begin
      ir = if_cyc && if_stb;
      dr = d_cyc && d_stb;
      if (owner == 0) begin
        if (ir && dr) owner = last_d ? 1 : 2;
        else if (ir) owner = 1;
        else if (dr) owner = 2;
        waited = 0;
      end else begin
        mine_req  = (owner == 1) ? ir : dr;
        other_req = (owner == 1) ? dr : ir;
        mine_cyc  = (owner == 1) ? if_cyc : d_cyc;
        if (m_ack) begin
          last_d = (owner == 2);
          waited = 0;
          if (other_req) owner = 3 - owner;
          else if (!mine_req) owner = 0;
        end else if (!mine_cyc) begin
          owner = 0;
        end else begin
          waited++;
          if (waited == TO) begin
            last_d = (owner == 2);
            err_m = 1;
            owner = 0;
          end
        end
      end
    end
  end

  // per-cycle compare of every output against the model
  initial forever begin
    @(negedge clk);
    case (owner)
      1: exp_bus = {if_cyc & if_stb, if_cyc & if_stb, if_we,
                    if_adr, if_dat_m, if_sel};
      2: exp_bus = {d_cyc & d_stb, d_cyc & d_stb, d_we,
                    d_adr, d_dat_m, d_sel};
      default: exp_bus = '0;
    endcase
    chk("bus", {m_cyc, m_stb, m_we, m_adr, m_dat_m, m_sel}, exp_bus);
    chk("acks", {if_ack, d_ack},
        {m_ack && owner == 1, m_ack && owner == 2});
    chk("rdata", {if_dat_s, d_dat_s}, {m_dat_s, m_dat_s});
    chk("terr", timeout_err, err_m);
  end

  // slave: acks the (ack_wait+1)-th consecutive strobe cycle
  initial forever begin
    @(posedge clk);
    #2;
    m_dat_s = {8{m_adr ^ 16'h5A5A}};
    if (m_stb) begin
      if (s_cnt >= ack_wait) begin
        m_ack = 1'b1;
        s_cnt = 0;
      end else begin
        m_ack = 1'b0;
        s_cnt++;
      end
    end else begin
      m_ack = 1'b0;
      s_cnt = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    i_seen = if_ack;
    d_seen = d_ack;
  end

  // masters retire one transfer per ack, then release the bus
  initial forever begin
    @(posedge clk);
    #1;
    if (i_seen && i_rem > 0) begin
      i_rem--;
      if (i_rem == 0) begin
        if_cyc = 1'b0;
        if_stb = 1'b0;
      end
    end
    if (d_seen && d_rem > 0) begin
      d_rem--;
      if (d_rem == 0) begin
        d_cyc = 1'b0;
        d_stb = 1'b0;
        d_we  = 1'b0;
      end
    end
  end

  task automatic go_i(input logic [AW-1:0] adr, input int n);
    i_rem    = n;
    if_adr   = adr;
    if_we    = 1'b0;
    if_sel   = '1;
    if_dat_m = {8{16'h1111}};
    if_cyc   = 1'b1;
    if_stb   = 1'b1;
  endtask

  task automatic go_d(input logic [AW-1:0] adr, input logic we,
                      input logic [SW-1:0] sel, input int n);
    d_rem   = n;
    d_adr   = adr;
    d_we    = we;
    d_sel   = sel;
    d_dat_m = {8{adr}};
    d_cyc   = 1'b1;
    d_stb   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string name, input int max);
    bit got = 0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clk);
      if (if_ack || d_ack) got = 1;
    end
    if (!got) begin
      cmp_n++;
      bad_n++;
      $display("FAIL %s actual=no_ack required=ack within %0d", name, max);
    end
  endtask

  int ia, da, sc, n, gap;
  logic [5:0] seq;
  logic [DW-1:0] cap;
  bit got;

  initial begin
    #12;
    chk("rst_bus", {m_cyc, m_stb, m_we, m_adr, m_dat_m, m_sel}, '0);
    chk("rst_acks", {if_ack, d_ack, timeout_err}, '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // fetch only, slave acks two cycles after strobe
    @(negedge clk);
    #1 go_i(16'h0010, 1);
    @(negedge clk);
    chk("f_stb", m_stb, 1'b1);
    chk("f_adr", m_adr, 16'h0010);
    ia = 0;
    da = 0;
    cap = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_ack) begin
        ia++;
        cap = if_dat_s;
      end
      if (d_ack) da++;
    end
    chk("f_ack_cnt", ia, 1);
    chk("f_dack_cnt", da, 0);
    chk("f_rdata", cap, {8{16'h5A4A}});

    // simultaneous request right after reset: data wins
    @(negedge clk);
    #1;
    go_i(16'h0020, 1);
    go_d(16'h1000, 1'b1, 16'h0030, 1);
    wait_ack("s_first", 10);
    chk("s_first_d", {d_ack, if_ack}, 2'b10);
    chk("s_we", {m_we, m_sel}, {1'b1, 16'h0030});
    @(negedge clk);
    chk("s_handover", {m_stb, m_adr}, {1'b1, 16'h0020});
    wait_ack("s_second", 10);
    chk("s_if_ack", if_ack, 1'b1);
    idle(3);

    // continuous requests with a zero-wait slave
    ack_wait = 0;
    @(negedge clk);
    #1;
    go_i(16'h0100, 3);
    go_d(16'h0200, 1'b0, 16'hFFFF, 3);
    seq = '0;
    n = 0;
    gap = 0;
    for (int k = 0; k < 30 && n < 6; k++) begin
      @(negedge clk);
      if (n > 0 && !m_cyc) gap++;
      if (if_ack || d_ack) begin
        seq = {seq[4:0], d_ack};
        n++;
      end
    end
    chk("alt_seq", seq, 6'b101010);
    chk("alt_n", n, 6);
    chk("alt_gap", gap, 0);
    idle(3);

    // data aborts before ack; last grant stays fetch
    ack_wait = 5;
    @(negedge clk);
    #1 go_d(16'h2000, 1'b0, 16'hFFFF, 1);
    da = 0;
    @(negedge clk);
    chk("ab_stb", m_stb, 1'b1);
    if (d_ack) da++;
    @(negedge clk);
    if (d_ack) da++;
    #1;
    d_cyc = 1'b0;
    d_stb = 1'b0;
    d_rem = 0;
    @(negedge clk);
    if (d_ack) da++;
    chk("ab_idle", m_cyc, 1'b0);
    chk("ab_no_dack", da, 0);
    chk("ab_model_idle", owner, 0);
    chk("ab_model_last", last_d, 1'b0);
    ack_wait = 2;
    @(negedge clk);
    #1;
    go_i(16'h0030, 1);
    go_d(16'h2100, 1'b0, 16'h000F, 1);
    wait_ack("ab_tie", 10);
    chk("ab_tie_d", {d_ack, if_ack}, 2'b10);
    wait_ack("ab_tie2", 10);
    idle(3);

    // slave never acks: watchdog frees the bus after TO cycles
    ack_wait = 1000;
    @(negedge clk);
    #1 go_i(16'h0040, 1);
    sc = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (m_stb) sc++;
      if (timeout_err) got = 1;
    end
    chk("to_cycles", sc, TO);
    chk("to_err", timeout_err, 1'b1);
    chk("to_idle", m_cyc, 1'b0);
    #1;
    if_cyc = 1'b0;
    if_stb = 1'b0;
    i_rem = 0;
    idle(2);
    ack_wait = 2;
    @(negedge clk);
    #1 go_i(16'h0050, 1);
    wait_ack("to_next", 10);
    chk("to_next_ack", if_ack, 1'b1);
    chk("to_sticky", timeout_err, 1'b1);
    idle(3);

    // reset while the slave ack is high
    @(negedge clk);
    #1 go_d(16'h3000, 1'b1, 16'h00FF, 1);
    wait_ack("r_ack", 10);
    #1 rst_n = 1'b0;
    #1;
    chk("r_bus", {m_cyc, m_stb, m_we, m_adr, m_dat_m, m_sel}, '0);
    chk("r_acks", {if_ack, d_ack}, 2'b00);
    chk("r_err", timeout_err, 1'b0);
    d_cyc = 1'b0;
    d_stb = 1'b0;
    d_we = 1'b0;
    d_rem = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("r_idle", m_cyc, 1'b0);
    chk("r_model", owner, 0);
    @(negedge clk);
    #1 go_i(16'h0060, 1);
    @(negedge clk);
    chk("r_regrant", {m_stb, m_adr}, {1'b1, 16'h0060});
    wait_ack("r_post", 10);
    chk("r_post_ack", if_ack, 1'b1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
